// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS32 pipeline: load-use bubbles, MEM-stage redirects,
// multi-cycle data-memory handshake with timeout halt, and stall/flush performance counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_memread,
   input  logic [4:0]       ex_writereg,
   input  logic             mem_branch,
   input  logic             mem_zero,
   input  logic             mem_jump,
   input  logic             mem_memread,
   input  logic             mem_memwrite,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             pc_sel,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int unsigned WC_W = ($clog2(MEM_TIMEOUT + 1) < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

   state_t          state, state_nxt;
   logic [WC_W-1:0] wcnt;
   logic            acc, taken, lu;
   logic            wc_load, wc_inc, err_set, stall_inc, flush_inc;

   assign acc   = mem_memread | mem_memwrite;
   assign taken = (mem_branch & mem_zero) | mem_jump;
   assign lu    = ex_memread & (ex_writereg != 5'd0) &
                  ((id_uses_rs & (id_rs == ex_writereg)) | (id_uses_rt & (id_rt == ex_writereg)));

   always_comb begin
      state_nxt   = state;
      dmem_req    = 1'b0;
      pc_en       = 1'b0;
      pc_sel      = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      wc_load     = 1'b0;
      wc_inc      = 1'b0;
      err_set     = 1'b0;
      case (state)
         RUN: begin
            if (acc && !dmem_ready) begin
               dmem_req  = 1'b1;
               wc_load   = 1'b1;
               state_nxt = MEM_WAIT;
            end else if (acc) begin
               dmem_req = 1'b1;
               {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
            end else if (taken) begin
               pc_sel = 1'b1;
               {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
               {ifid_flush, idex_flush, exmem_flush} = '1;
            end else if (lu) begin
               idex_en    = 1'b1;
               idex_flush = 1'b1;
               exmem_en   = 1'b1;
               memwb_en   = 1'b1;
            end else begin
               {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
            end
         end
         MEM_WAIT: begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
               {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
               state_nxt = RUN;
            end else if ((MEM_TIMEOUT != 0) && (wcnt == WC_W'(MEM_TIMEOUT))) begin
               err_set   = 1'b1;
               state_nxt = HALT;
            end else begin
               wc_inc = 1'b1;
            end
         end
         default: ;
      endcase
      // Reset forces every control low immediately so an outstanding request is aborted.
      if (reset) begin
         dmem_req = 1'b0;
         {pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en} = '0;
         {ifid_flush, idex_flush, exmem_flush} = '0;
      end
   end

   assign stall_inc = (state != HALT) && !pc_en;
   assign flush_inc = (state == RUN) && pc_sel;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= RUN;
         wcnt         <= '0;
         mem_error    <= 1'b0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         state <= state_nxt;
         if (wc_load)
            wcnt <= WC_W'(1);
         else if (wc_inc && (MEM_TIMEOUT != 0))
            wcnt <= wcnt + WC_W'(1);
         if (err_set)
            mem_error <= 1'b1;
         if (stall_inc && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (flush_inc && (flush_count != '1))
            flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS32 pipeline. It drives the per-stage enable and flush controls of IF/ID, ID/EX, EX/MEM and MEM/WB, and the PC enable and PC redirect select. It resolves three hazard classes:
- load-use data hazards;
- taken branches and jumps resolved in MEM;
- multi-cycle data-memory accesses via a req/ready handshake, with a timeout that halts the pipeline.

It also keeps stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 64, maximum MEM_WAIT cycles before a fatal halt; 0 disables the timeout
CNT_W, 32, width of the performance counters

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
id_rs  input  5  rs field of the instruction in ID
id_rt  input  5  rt field of the instruction in ID
id_uses_rs  input  1  ID instruction reads rs
id_uses_rt  input  1  ID instruction reads rt
ex_memread  input  1  ID/EX stage holds a load
ex_writereg  input  5  destination register of the ID/EX instruction
mem_branch  input  1  EX/MEM Branch
mem_zero  input  1  EX/MEM zero flag
mem_jump  input  1  EX/MEM Jump
mem_memread  input  1  EX/MEM MemRead
mem_memwrite  input  1  EX/MEM MemWrite
dmem_ready  input  1  data memory completes the access this cycle
dmem_req  output  1  data memory access request
pc_en  output  1  PC register update enable
pc_sel  output  1  1 = load EX/MEM PC_beq, 0 = PC+4
ifid_en, idex_en, exmem_en, memwb_en  output  1 each  pipeline register load enables
ifid_flush, idex_flush, exmem_flush  output  1 each  synchronous bubble insert; only meaningful when the matching _en is 1
mem_error  output  1  sticky flag: memory timeout occurred
stall_cycles  output  CNT_W  count of cycles with pc_en=0 while in RUN or MEM_WAIT
flush_count  output  CNT_W  count of redirect events

Behaviour:
- The reset signal is asynchronous, active-high; the clock is clk.
- During reset and immediately after it: state=RUN, wait counter=0, mem_error=0, both counters=0.
- While reset is asserted, all _en=0, all _flush=0, dmem_req=0, pc_sel=0.
- All stage controls are combinational from state plus the current inputs.
- Signal definitions:
  - acc = mem_memread | mem_memwrite.
  - taken = (mem_branch & mem_zero) | mem_jump.
  - lu = ex_memread & (ex_writereg != 0) & ((id_uses_rs & id_rs == ex_writereg) | (id_uses_rt & id_rt == ex_writereg)).
- States: RUN, MEM_WAIT, HALT.
- RUN, priority order (highest first):
  1. acc & !dmem_ready: dmem_req=1, all _en=0, next state=MEM_WAIT, wait counter loads 1.
  2. acc & dmem_ready: dmem_req=1, normal advance (all _en=1, no flush). A single-cycle access costs no stall.
  3. taken: pc_sel=1, all _en=1, ifid_flush=idex_flush=exmem_flush=1, flush_count+1. lu is ignored.
  4. lu: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1, exmem_en=memwb_en=1. Exactly one bubble per hazard; the next cycle sees ex_memread=0.
  5. Otherwise: all _en=1, no flush, pc_sel=0.
- MEM_WAIT:
  - dmem_req=1 (held high until dmem_ready is sampled high) and all _en=0.
  - On dmem_ready=1: all _en=1 in that cycle, no flush, next state=RUN. taken and lu are evaluated only from the following RUN cycle.
  - Otherwise the wait counter increments. If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT with dmem_ready=0, the next state is HALT and mem_error is set.
- HALT:
  - All _en=0, dmem_req=0, counters frozen, mem_error=1.
  - Exit only through reset. Reset mid-wait also aborts the request immediately (dmem_req drops asynchronously).
- stall_cycles increments on every RUN or MEM_WAIT cycle with pc_en=0. This covers case 1, case 4 and every MEM_WAIT cycle except the one completing with dmem_ready=1.
- Both counters saturate at all-ones; no wrap.
- Wait counter width is clog2(MEM_TIMEOUT+1), minimum 1.
- Register $0 never causes a load-use stall.

Test Plan:
1. Load-use: ex_memread=1, ex_writereg=5, id_uses_rt=1, id_rt=5 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; stall_cycles=1; the next cycle (ex_memread=0) is a normal advance. Repeat with ex_writereg=0 -> no stall.
2. Branch taken: mem_branch=1, mem_zero=1, with a simultaneous lu condition -> pc_sel=1, three flushes, pc_en=1, flush_count=1, no stall. mem_branch=1, mem_zero=0 -> no redirect.
3. Multi-cycle load: mem_memread=1, dmem_ready low for 3 cycles then high -> dmem_req high for 4 cycles, all _en=0 for 3 cycles, advance on the 4th; stall_cycles=3; state back to RUN. dmem_ready high on the first cycle -> zero stall.
4. Timeout with MEM_TIMEOUT=4: mem_memwrite=1, dmem_ready never asserted -> HALT entered after 4 wait cycles; mem_error=1; all _en=0 and dmem_req=0 thereafter; counters frozen.
5. Reset mid-MEM_WAIT: assert reset asynchronously -> dmem_req and all _en drop to 0 in the same cycle; after release, state=RUN, mem_error=0, counters=0.
6. Saturation with CNT_W=4: 20 consecutive load-use stalls -> stall_cycles holds at 15.
